multicycle_alu: RTL and testbench

//   Parametrised, registered successor of the single-cycle datapath ALU. Adds a

---
 rtl/multicycle_alu_if.sv | 35 +++
 rtl/multicycle_alu.sv | 159 +++++++++++++++
 tb/tb_multicycle_alu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - operand/request and result bundle for multicycle_alu
// Overflow is present only when ALU_OVERFLOW_EN is defined.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
`ifdef ALU_OVERFLOW_EN
  logic             Overflow;
`endif

  modport master (
    output start, ALUOperation, A, B,
`ifdef ALU_OVERFLOW_EN
    input  Overflow,
`endif
    input  busy, done, ALUResult, Zero, HI, LO
  );

  modport slave (
    input  start, ALUOperation, A, B,
`ifdef ALU_OVERFLOW_EN
    output Overflow,
`endif
    output busy, done, ALUResult, Zero, HI, LO
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with iterative MULTU/DIVU into HI/LO
// Optional feature macro: ALU_OVERFLOW_EN (adds the Overflow output and its logic).
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_LUI  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start && bus.ALUOperation == OP_MULT)     next_state = MUL;
        else if (bus.start && bus.ALUOperation == OP_DIV) next_state = DIV;
      end
      MUL, DIV: if (cnt_q == LAST) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (bus.ALUOperation)
      OP_AND: alu_res = bus.A & bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_NOR: alu_res = ~(bus.A | bus.B);
      OP_ADD: alu_res = bus.A + bus.B;
      OP_SUB: alu_res = bus.A - bus.B;
      OP_LUI: alu_res = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL: alu_res = bus.B << bus.A[SHW-1:0];
      OP_SRL: alu_res = bus.B >> bus.A[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (bus.ALUOperation == OP_ADD)
      alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
    else if (bus.ALUOperation == OP_SUB)
      alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
  end
`endif

  // {hi_q,lo_q} is the shift-add product register for MUL and the
  // remainder/quotient pair for DIV; opnd_q holds multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (state == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (div_shift >= {1'b0, opnd_q}) begin
      step_hi = div_diff;
      step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q          <= '0;
      lo_q          <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      bus.done      <= 1'b0;
      bus.ALUResult <= '0;
      bus.Zero      <= 1'b0;
      bus.HI        <= '0;
      bus.LO        <= '0;
`ifdef ALU_OVERFLOW_EN
      bus.Overflow  <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt_q <= '0;
            if (bus.ALUOperation == OP_MULT) begin
              hi_q   <= '0;
              lo_q   <= bus.B;
              opnd_q <= bus.A;
            end else if (bus.ALUOperation == OP_DIV) begin
              hi_q   <= '0;
              lo_q   <= bus.A;
              opnd_q <= bus.B;
            end else begin
              bus.ALUResult <= alu_res;
              bus.Zero      <= (alu_res == '0);
              bus.done      <= 1'b1;
`ifdef ALU_OVERFLOW_EN
              bus.Overflow  <= alu_ovf;
`endif
            end
          end
        end
        MUL, DIV: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          // A zero divisor needs no special case: every trial subtract
          // succeeds, giving an all-ones quotient and remainder A.
          if (cnt_q == LAST) begin
            bus.HI        <= step_hi;
            bus.LO        <= step_lo;
            bus.ALUResult <= step_lo;
            bus.Zero      <= (step_lo == '0);
            bus.done      <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            bus.Overflow  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu (WIDTH=32)
// Build with ALU_OVERFLOW_EN defined to also check the Overflow output.
module tb_multicycle_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  multicycle_alu_if #(.WIDTH(W)) bus();
  multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.done) begin
      chk("busy_with_done", W'(bus.busy), '0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("result",  bus.ALUResult, e.res);
        chk("zero",    W'(bus.Zero), W'(e.res == '0));
        chk("hi",      bus.HI, e.hi);
        chk("lo",      bus.LO, e.lo);
        chk("latency", W'(cyc), W'(e.due));
`ifdef ALU_OVERFLOW_EN
        chk("overflow", W'(bus.Overflow), W'(e.ovf));
`endif
      end
    end
  end

  // Called just after a negedge; start is held across exactly one rising edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic ovf, input int lat, input bit expect_it);
    exp_t e;
    bus.start        = 1'b1;
    bus.ALUOperation = op;
    bus.A            = a;
    bus.B            = b;
    if (expect_it) begin
      e.res = res;
      e.hi  = hi;
      e.lo  = lo;
      e.ovf = ovf;
      e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic ovf);
    issue(op, a, b, res, m_hi, m_lo, ovf, 1, 1'b1);
  endtask

  task automatic longop(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    m_hi = hi;
    m_lo = lo;
    issue(op, a, b, lo, hi, lo, 1'b0, W + 1, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    bus.start        = 1'b0;
    bus.ALUOperation = 4'd0;
    bus.A            = '0;
    bus.B            = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   W'(bus.busy), '0);
    chk("reset_done",   W'(bus.done), '0);
    chk("reset_result", bus.ALUResult, '0);
    chk("reset_zero",   W'(bus.Zero), '0);
    chk("reset_hi",     bus.HI, '0);
    chk("reset_lo",     bus.LO, '0);
    reset = 1'b1;
    @(negedge clk);

    single(4'd3,  32'd5,        32'd7,        32'd12,       1'b0);
    single(4'd4,  32'd7,        32'd7,        32'd0,        1'b0);
    single(4'd0,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
    single(4'd1,  32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b0);
    single(4'd2,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0);
    single(4'd6,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0);
    single(4'd6,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);
    single(4'd7,  32'h23,       32'd1,        32'd8,        1'b0);
    single(4'd7,  32'd31,       32'd1,        32'h80000000, 1'b0);
    single(4'd8,  32'd4,        32'h80000000, 32'h08000000, 1'b0);
    single(4'd5,  32'hDEAD,     32'h1234,     32'h12340000, 1'b0);
    single(4'd12, 32'd5,        32'd7,        32'd0,        1'b0);
    single(4'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0);
    single(4'd3,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1);
    single(4'd4,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1);
    drain();

    longop(4'd9, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE);
    drain();

    // Start during busy is dropped; start in the done cycle is taken.
    longop(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);
    repeat (3) @(negedge clk);
    issue(4'd3, 32'd5, 32'd7, '0, '0, '0, 1'b0, 1, 1'b0);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    single(4'd3, 32'd3, 32'd4, 32'd7, 1'b0);
    drain();

    longop(4'd10, 32'd100, 32'd7, 32'd2,   32'd14);
    drain();
    longop(4'd10, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    drain();

    longop(4'd10, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;
    chk("abort_busy",   W'(bus.busy), '0);
    chk("abort_done",   W'(bus.done), '0);
    chk("abort_hi",     bus.HI, '0);
    chk("abort_lo",     bus.LO, '0);
    chk("abort_result", bus.ALUResult, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    single(4'd3, 32'd1, 32'd1, 32'd2, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    chk("idle_hold_result", bus.ALUResult, 32'd2);
    chk("idle_hold_done",   W'(bus.done), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
